pwm_ramp_sequencer: RTL
=======================

Name: pwm_ramp_sequencer

Overview:
- Sequences the duty-cycle input of the PWM controller. Accepts target duty-cycle requests over a valid/ready handshake and ramps the applied duty cycle toward the target in programmable steps.
- Updates happen only on PWM period boundaries, so the generated waveform never glitches mid-period.
- Clamps out-of-range targets and raises a sticky interrupt to the PS.
- Sits between the AXI register slice (upstream) and the PWM controller DutyCycle input (downstream).

Parameters:
- PERIOD_BITS, 20, width of the PWM period counter; the Step port is this wide.
- DUTY_MAX, 990000, largest legal duty cycle; larger targets are clamped to this value.

Ports:
- Clk, input, 1, system clock.
- Reset, input, 1, asynchronous active-low reset.
- Target, input, 32, requested duty cycle.
- Target_valid, input, 1, Target is valid.
- Target_ready, output, 1, block can accept a new Target.
- Step, input, PERIOD_BITS, ramp increment per PWM period; 0 means jump directly to target.
- Period_tick, input, 1, one-cycle pulse when the PWM counter wraps to 0.
- Abort, input, 1, stop the ramp and hold the current duty.
- Int_clear, input, 1, clears Interrupt.
- DutyCycle, output, 32, applied duty cycle to the PWM controller.
- Busy, output, 1, ramp in progress.
- Done, output, 1, one-cycle pulse when the target is reached.
- Interrupt, output, 1, sticky flag: a clamped target was accepted.

Behaviour:
- Reset (async assert, sync release): DutyCycle=0, Interrupt=0, Done=0, Busy=0, Target_ready=0 while Reset is low. State=IDLE.
- States: IDLE, RAMP.
- IDLE:
  - Target_ready=1, Busy=0.
  - On Target_valid & Target_ready, capture tgt = min(Target, DUTY_MAX) and move to RAMP next cycle.
  - If Target > DUTY_MAX, set Interrupt.
- RAMP:
  - Target_ready=0, Busy=1. Step is sampled at every tick, not latched.
  - On each Period_tick, update DutyCycle the same cycle, registered and visible the next cycle:
    - DutyCycle < tgt: DutyCycle = min(DutyCycle+Step, tgt).
    - DutyCycle > tgt: DutyCycle = max(DutyCycle-Step, tgt). Subtraction must never underflow.
    - Step == 0: DutyCycle = tgt.
  - Arithmetic is 33-bit, so DutyCycle+Step never wraps.
  - On the tick where the new DutyCycle equals tgt, including the case where it already equalled tgt: Done=1 for one cycle and return to IDLE.
  - Between ticks, DutyCycle holds.
- Abort:
  - In RAMP: go to IDLE next cycle and hold DutyCycle at its current value. No Done.
  - Abort on the same cycle as Period_tick: Abort wins, no duty update.
  - Abort in IDLE: ignored.
- Interrupt:
  - Set on clamped acceptance and held until Int_clear.
  - Clamped acceptance on the same cycle as Int_clear: set wins.
- Target_valid while in RAMP: not accepted. Target must be held by upstream until the handshake completes.
- Reset asserted mid-ramp: everything returns to reset values immediately. DutyCycle=0, so the PWM output goes low.

Decomposition:
- Package pwm_pkg:
  - state enum (IDLE, RAMP).
  - DUTY_MAX default constant.
  - DUTY_W=32.
- One natural sub-module, pwm_step_calc: combinational saturating step toward target (inputs cur, tgt, step; output next). It is reused by future multi-channel sequencers.

Test Plan:
1. Reset; send Target=1000, Step=300; apply 4 ticks -> DutyCycle 300, 600, 900, 1000. Done pulses on the 4th tick; Busy falls; Interrupt=0.
2. From DutyCycle=1000, send Target=100, Step=400 -> DutyCycle 600, 200, 100, then Done. No underflow.
3. Send Target=2000000, Step=0 -> Interrupt=1, DutyCycle=990000 after the first tick. Pulse Int_clear -> Interrupt=0.
4. Ramp 0→5000 with Step=1000; assert Abort on the same cycle as the 3rd tick -> DutyCycle holds 2000, no Done, Target_ready=1 next cycle.
5. Hold Target_valid during RAMP with a new Target -> not accepted until IDLE. The new target is then captured and ramped correctly.
6. Assert Reset mid-ramp (DutyCycle=3000) -> DutyCycle, Busy and Interrupt=0 asynchronously, before the next Clk edge.

Source files
------------

// File: rtl/pwm_pkg.sv
// pwm_pkg: shared types and constants for the PWM duty-cycle sequencer
package pwm_pkg;
   localparam int DUTY_W = 32;
   localparam logic [DUTY_W-1:0] DUTY_MAX_DEF = 32'd990000;
   typedef enum logic {IDLE, RAMP} state_t;
endpackage

// File: rtl/pwm_step_calc.sv
// pwm_step_calc: one saturating step of cur toward tgt, never overshooting or underflowing
module pwm_step_calc
   import pwm_pkg::*;
#(
   parameter int W = 20
) (
   input  logic [DUTY_W-1:0] cur,
   input  logic [DUTY_W-1:0] tgt,
   input  logic [W-1:0]      step,
   output logic [DUTY_W-1:0] next
);
   logic [DUTY_W:0]   sum;
   logic [DUTY_W-1:0] step_ext;
   always_comb begin
      step_ext = {{(DUTY_W-W){1'b0}}, step};
      sum      = {1'b0, cur} + {1'b0, step_ext};
      next     = (step == '0 || cur == tgt) ? tgt :
                 (cur < tgt) ? ((sum > {1'b0, tgt}) ? tgt : sum[DUTY_W-1:0]) :
                 ((cur - tgt > step_ext) ? cur - step_ext : tgt);
   end
endmodule

// File: rtl/pwm_ramp_sequencer.sv
// pwm_ramp_sequencer: ramps the applied PWM duty toward a clamped target on period boundaries
module pwm_ramp_sequencer
   import pwm_pkg::*;
#(
   parameter int                PERIOD_BITS = 20,
   parameter logic [DUTY_W-1:0] DUTY_MAX    = DUTY_MAX_DEF
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [DUTY_W-1:0]      target,
   input  logic                   target_valid,
   output logic                   target_ready,
   input  logic [PERIOD_BITS-1:0] step,
   input  logic                   period_tick,
   input  logic                   abort,
   input  logic                   int_clear,
   output logic [DUTY_W-1:0]      duty_cycle,
   output logic                   busy,
   output logic                   done,
   output logic                   interrupt
);
   state_t            state_q, state_d;
   logic [DUTY_W-1:0] tgt_q, tgt_d, duty_q, duty_d, duty_nxt;
   logic              done_q, done_d, irq_q, irq_d;

   pwm_step_calc #(.W(PERIOD_BITS)) u_step (
      .cur  (duty_q),
      .tgt  (tgt_q),
      .step (step),
      .next (duty_nxt)
   );

   always_comb begin
      state_d = state_q;
      tgt_d   = tgt_q;
      duty_d  = duty_q;
      done_d  = 1'b0;
      irq_d   = irq_q & ~int_clear;
      if (state_q == IDLE) begin
         if (target_valid) begin
            tgt_d   = (target > DUTY_MAX) ? DUTY_MAX : target;
            irq_d   = irq_d | (target > DUTY_MAX);
            state_d = RAMP;
         end
      end else if (abort) begin
         state_d = IDLE;
      end else if (period_tick) begin
         duty_d  = duty_nxt;
         done_d  = (duty_nxt == tgt_q);
         state_d = (duty_nxt == tgt_q) ? IDLE : RAMP;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         tgt_q   <= '0;
         duty_q  <= '0;
         done_q  <= 1'b0;
         irq_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         tgt_q   <= tgt_d;
         duty_q  <= duty_d;
         done_q  <= done_d;
         irq_q   <= irq_d;
      end
   end

   // ready is gated by reset so upstream never handshakes while held in reset
   assign target_ready = rst_n && state_q == IDLE;
   assign busy         = state_q == RAMP;
   assign done         = done_q;
   assign interrupt    = irq_q;
   assign duty_cycle   = duty_q;
endmodule
